// File: rtl/dvg_fetch_seq_if.sv
// Signal bundle between the vector-generator fetch sequencer and its environment
// (PC block, vector ROM, vector datapath).
interface dvg_fetch_seq_if;
    logic        go;
    logic [15:0] vram_data;
    logic        vec_ready;
    logic        latch0;
    logic        latch2;
    logic        dmapush;
    logic        dmaload;
    logic        load_pc;
    logic [11:0] count_in;
    logic        vec_valid;
    logic [3:0]  vec_op;
    logic [15:0] vec_w0;
    logic [15:0] vec_w1;
    logic        busy;
    logic        halted;
    logic        stack_err;

    modport slave (
        input  go, vram_data, vec_ready,
        output latch0, latch2, dmapush, dmaload, load_pc, count_in,
               vec_valid, vec_op, vec_w0, vec_w1, busy, halted, stack_err
    );

    modport master (
        output go, vram_data, vec_ready,
        input  latch0, latch2, dmapush, dmaload, load_pc, count_in,
               vec_valid, vec_op, vec_w0, vec_w1, busy, halted, stack_err
    );
endinterface

// File: rtl/dvg_fetch_seq.sv
// Vector-generator fetch/decode sequencer: steps the PC block, decodes ROM words,
// tracks subroutine depth and issues draw instructions over valid/ready.
module dvg_fetch_seq #(
    parameter int unsigned MEM_LAT     = 1,
    parameter logic [11:0] START_ADDR  = 12'h000,
    parameter int unsigned STACK_DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    dvg_fetch_seq_if.slave bus
);

    localparam int unsigned LAT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [LAT_W-1:0]   LAT_INIT  = LAT_W'(MEM_LAT - 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    typedef enum logic [3:0] {
        IDLE, START, WAIT0, FETCH0, DECODE, WAIT1,
        FETCH1, ISSUE, PUSH, JUMP, POP, HALTED
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [15:0]        ir0_q, ir0_d;
    logic [15:0]        ir1_q, ir1_d;
    logic               stack_err_q, stack_err_d;

    logic        latch0_q, latch0_d;
    logic        latch2_q, latch2_d;
    logic        dmapush_q, dmapush_d;
    logic        dmaload_q, dmaload_d;
    logic        load_pc_q, load_pc_d;
    logic [11:0] count_in_q, count_in_d;
    logic        vec_valid_q, vec_valid_d;
    logic [3:0]  vec_op_q, vec_op_d;
    logic [15:0] vec_w0_q, vec_w0_d;
    logic [15:0] vec_w1_q, vec_w1_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        depth_d     = depth_q;
        ir0_d       = ir0_q;
        ir1_d       = ir1_q;
        stack_err_d = stack_err_q;

        unique case (state_q)
            IDLE, HALTED: begin
                if (bus.go && !stack_err_q) begin
                    state_d = START;
                    depth_d = '0;
                end
            end
            START, JUMP, POP: begin
                state_d = WAIT0;
                cnt_d   = LAT_INIT;
            end
            WAIT0: begin
                if (cnt_q == '0) state_d = FETCH0;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FETCH0: begin
                ir0_d   = bus.vram_data;
                state_d = DECODE;
            end
            DECODE: begin
                unique case (ir0_q[15:12])
                    4'hB: state_d = HALTED;
                    4'hC: begin
                        if (depth_q == DEPTH_MAX) begin
                            stack_err_d = 1'b1;
                            state_d     = HALTED;
                        end else begin
                            depth_d = depth_q + 1'b1;
                            state_d = PUSH;
                        end
                    end
                    4'hD: begin
                        if (depth_q == '0) begin
                            stack_err_d = 1'b1;
                            state_d     = HALTED;
                        end else begin
                            depth_d = depth_q - 1'b1;
                            state_d = POP;
                        end
                    end
                    4'hE: state_d = JUMP;
                    4'hF: begin
                        ir1_d   = '0;
                        state_d = ISSUE;
                    end
                    default: begin
                        state_d = WAIT1;
                        cnt_d   = LAT_INIT;
                    end
                endcase
            end
            WAIT1: begin
                if (cnt_q == '0) state_d = FETCH1;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FETCH1: begin
                ir1_d   = bus.vram_data;
                state_d = ISSUE;
            end
            ISSUE: begin
                // vec_valid is high throughout ISSUE, so ready alone completes the handshake
                if (bus.vec_ready) begin
                    state_d = WAIT0;
                    cnt_d   = LAT_INIT;
                end
            end
            PUSH:    state_d = JUMP;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it
    always_comb begin
        latch0_d    = (state_d == FETCH0);
        latch2_d    = (state_d == FETCH1);
        dmapush_d   = (state_d == PUSH);
        dmaload_d   = (state_d == START) || (state_d == JUMP) || (state_d == POP);
        load_pc_d   = (state_d == START) || (state_d == JUMP);
        count_in_d  = '0;
        if (state_d == START)     count_in_d = START_ADDR;
        else if (state_d == JUMP) count_in_d = ir0_d[11:0];
        vec_valid_d = (state_d == ISSUE);
        vec_op_d    = vec_valid_d ? ir0_d[15:12] : '0;
        vec_w0_d    = vec_valid_d ? ir0_d : '0;
        vec_w1_d    = vec_valid_d ? ir1_d : '0;
        busy_d      = (state_d != IDLE) && (state_d != HALTED);
        halted_d    = (state_d == HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            depth_q     <= '0;
            ir0_q       <= '0;
            ir1_q       <= '0;
            stack_err_q <= 1'b0;
            latch0_q    <= 1'b0;
            latch2_q    <= 1'b0;
            dmapush_q   <= 1'b0;
            dmaload_q   <= 1'b0;
            load_pc_q   <= 1'b0;
            count_in_q  <= '0;
            vec_valid_q <= 1'b0;
            vec_op_q    <= '0;
            vec_w0_q    <= '0;
            vec_w1_q    <= '0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            depth_q     <= depth_d;
            ir0_q       <= ir0_d;
            ir1_q       <= ir1_d;
            stack_err_q <= stack_err_d;
            latch0_q    <= latch0_d;
            latch2_q    <= latch2_d;
            dmapush_q   <= dmapush_d;
            dmaload_q   <= dmaload_d;
            load_pc_q   <= load_pc_d;
            count_in_q  <= count_in_d;
            vec_valid_q <= vec_valid_d;
            vec_op_q    <= vec_op_d;
            vec_w0_q    <= vec_w0_d;
            vec_w1_q    <= vec_w1_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.latch0    = latch0_q;
    assign bus.latch2    = latch2_q;
    assign bus.dmapush   = dmapush_q;
    assign bus.dmaload   = dmaload_q;
    assign bus.load_pc   = load_pc_q;
    assign bus.count_in  = count_in_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.vec_op    = vec_op_q;
    assign bus.vec_w0    = vec_w0_q;
    assign bus.vec_w1    = vec_w1_q;
    assign bus.busy      = busy_q;
    assign bus.halted    = halted_q;
    assign bus.stack_err = stack_err_q;

endmodule
